// File: rtl/dand_monitor_pkg.sv
// dand_monitor_pkg: shared types and helpers for the run monitor.
// Rev 1.0
`default_nettype none

package dand_monitor_pkg;

  localparam int MAX_COMMIT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_STALL   = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counts set bits among the lowest n lanes; callers zero-pad narrower vectors.
  function automatic logic [2:0] popcount(input logic [MAX_COMMIT_W-1:0] lanes, input int n);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_COMMIT_W; i++) begin
      if (i < n && lanes[i]) begin
        cnt = cnt + 3'd1;
      end
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dand_run_monitor_if.sv
// dand_run_monitor_if: commit-lane observation, run control and statistics bundle.
// Rev 1.0
`default_nettype none

interface dand_run_monitor_if #(
  parameter int COMMIT_W = 1,
  parameter int PC_W     = 64,
  parameter int CNT_W    = 64
);

  logic                     io_enable;
  logic                     io_clear;
  logic [COMMIT_W-1:0]      io_commit_valid;
  logic [COMMIT_W*PC_W-1:0] io_commit_pc;
  logic                     io_halt_pc_en;
  logic [PC_W-1:0]          io_halt_pc;
  logic [CNT_W-1:0]         io_cycle_cnt;
  logic [CNT_W-1:0]         io_instr_cnt;
  logic [PC_W-1:0]          io_last_pc;
  logic [1:0]               io_status;
  logic                     io_done;

  modport master (
    output io_enable, io_clear, io_commit_valid, io_commit_pc, io_halt_pc_en, io_halt_pc,
    input  io_cycle_cnt, io_instr_cnt, io_last_pc, io_status, io_done
  );

  modport slave (
    input  io_enable, io_clear, io_commit_valid, io_commit_pc, io_halt_pc_en, io_halt_pc,
    output io_cycle_cnt, io_instr_cnt, io_last_pc, io_status, io_done
  );

endinterface

`default_nettype wire

// File: rtl/dand_sat_counter.sv
// dand_sat_counter: clearable up-counter with variable increment, saturating at MAX.
// Rev 1.0
`default_nettype none

module dand_sat_counter #(
  parameter int             W     = 8,
  parameter int             INC_W = 1,
  parameter logic [W-1:0]   MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     cnt
);

  // One extra bit so an overflowing sum is caught before it wraps.
  logic [W:0] sum;

  assign sum = {1'b0, cnt} + (W+1)'(inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (sum > {1'b0, MAX}) ? MAX : sum[W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dand_run_monitor.sv
// dand_run_monitor: counts run cycles and retirements; ends a run on halt PC, stall or timeout.
// Rev 1.0
`default_nettype none

module dand_run_monitor
  import dand_monitor_pkg::*;
#(
  parameter int COMMIT_W       = 1,
  parameter int PC_W           = 64,
  parameter int CNT_W          = 64,
  parameter int TIMEOUT_CYCLES = 20000000,
  parameter int STALL_LIMIT    = 100000
) (
  input  logic             io_axiClk,
  input  logic             io_asyncResetn,
  dand_run_monitor_if.slave bus
);

  localparam int INC_W   = $clog2(COMMIT_W + 1);
  localparam int STALL_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

  state_e              state;
  status_e             status;
  logic                done;
  logic [PC_W-1:0]     last_pc;

  logic                active;
  logic                any_commit;
  logic                halt_hit;
  logic                stall_hit;
  logic                timeout_hit;
  logic [PC_W-1:0]     top_pc;
  logic [INC_W-1:0]    inc_instr;
  logic [STALL_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [CNT_W-1:0]    instr_cnt;

  // The enabling cycle already counts, so activity tracks io_enable outside DONE.
  assign active     = bus.io_enable && !bus.io_clear && (state != S_DONE);
  assign any_commit = |bus.io_commit_valid;
  assign inc_instr  = INC_W'(popcount(MAX_COMMIT_W'(bus.io_commit_valid), COMMIT_W));

  always_comb begin
    halt_hit = 1'b0;
    top_pc   = last_pc;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (bus.io_commit_valid[i]) begin
        top_pc = bus.io_commit_pc[i*PC_W +: PC_W];
        if (bus.io_commit_pc[i*PC_W +: PC_W] == bus.io_halt_pc) begin
          halt_hit = 1'b1;
        end
      end
    end
    halt_hit = halt_hit && bus.io_halt_pc_en;
  end

  assign stall_hit   = (STALL_LIMIT != 0) && !any_commit &&
                       (stall_cnt == STALL_W'(STALL_LIMIT - 1));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  dand_sat_counter #(
    .W     (CNT_W),
    .INC_W (1),
    .MAX   ({CNT_W{1'b1}})
  ) u_cycle_cnt (
    .clk   (io_axiClk),
    .rst_n (io_asyncResetn),
    .clr   (bus.io_clear),
    .en    (active),
    .inc   (1'b1),
    .cnt   (cycle_cnt)
  );

  dand_sat_counter #(
    .W     (CNT_W),
    .INC_W (INC_W),
    .MAX   ({CNT_W{1'b1}})
  ) u_instr_cnt (
    .clk   (io_axiClk),
    .rst_n (io_asyncResetn),
    .clr   (bus.io_clear),
    .en    (active),
    .inc   (inc_instr),
    .cnt   (instr_cnt)
  );

  // Any retirement restarts the no-commit window.
  dand_sat_counter #(
    .W     (STALL_W),
    .INC_W (1),
    .MAX   (STALL_W'(STALL_LIMIT))
  ) u_stall_cnt (
    .clk   (io_axiClk),
    .rst_n (io_asyncResetn),
    .clr   (bus.io_clear || (active && any_commit)),
    .en    (active),
    .inc   (1'b1),
    .cnt   (stall_cnt)
  );

  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state   <= S_IDLE;
      status  <= ST_RUN;
      done    <= 1'b0;
      last_pc <= '0;
    end else if (bus.io_clear) begin
      state   <= S_IDLE;
      status  <= ST_RUN;
      done    <= 1'b0;
      last_pc <= '0;
    end else begin
      case (state)
        S_IDLE, S_RUN: begin
          if (bus.io_enable) begin
            if (any_commit) begin
              last_pc <= top_pc;
            end
            if (halt_hit) begin
              state  <= S_DONE;
              status <= ST_HALT;
              done   <= 1'b1;
            end else if (stall_hit) begin
              state  <= S_DONE;
              status <= ST_STALL;
              done   <= 1'b1;
            end else if (timeout_hit) begin
              state  <= S_DONE;
              status <= ST_TIMEOUT;
              done   <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.io_cycle_cnt = cycle_cnt;
  assign bus.io_instr_cnt = instr_cnt;
  assign bus.io_last_pc   = last_pc;
  assign bus.io_status    = status;
  assign bus.io_done      = done;

endmodule

`default_nettype wire

// File: tb/tb_dand_run_monitor.sv
// tb_dand_run_monitor: directed checks of timeout, halt, stall, clear, pause and saturation.
// Rev 1.0
`default_nettype none

module tb_dand_run_monitor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dand_run_monitor_if #(.COMMIT_W(1), .PC_W(32), .CNT_W(32)) b1 ();
  dand_run_monitor_if #(.COMMIT_W(2), .PC_W(64), .CNT_W(64)) b2 ();
  dand_run_monitor_if #(.COMMIT_W(1), .PC_W(16), .CNT_W(8))  b3 ();

  dand_run_monitor #(
    .COMMIT_W(1), .PC_W(32), .CNT_W(32), .TIMEOUT_CYCLES(1000), .STALL_LIMIT(16)
  ) u1 (.io_axiClk(clk), .io_asyncResetn(rst_n), .bus(b1));

  dand_run_monitor #(
    .COMMIT_W(2), .PC_W(64), .CNT_W(64), .TIMEOUT_CYCLES(20000000), .STALL_LIMIT(100000)
  ) u2 (.io_axiClk(clk), .io_asyncResetn(rst_n), .bus(b2));

  dand_run_monitor #(
    .COMMIT_W(1), .PC_W(16), .CNT_W(8), .TIMEOUT_CYCLES(0), .STALL_LIMIT(0)
  ) u3 (.io_axiClk(clk), .io_asyncResetn(rst_n), .bus(b3));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_b1_zero(input string tag);
    check({tag, "_cyc"},    64'(b1.io_cycle_cnt), 64'd0);
    check({tag, "_instr"},  64'(b1.io_instr_cnt), 64'd0);
    check({tag, "_lastpc"}, 64'(b1.io_last_pc),   64'd0);
    check({tag, "_status"}, 64'(b1.io_status),    64'd0);
    check({tag, "_done"},   64'(b1.io_done),      64'd0);
  endtask

  task automatic clear_b1();
    b1.io_clear        = 1'b1;
    b1.io_enable       = 1'b0;
    b1.io_commit_valid = 1'b0;
    tick(1);
    b1.io_clear = 1'b0;
  endtask

  logic [1:0]  pat [4];
  logic [63:0] exp_first [4];
  logic [63:0] halt2;

  initial begin
    pat       = '{2'b11, 2'b01, 2'b00, 2'b10};
    exp_first = '{64'h1004, 64'h1008, 64'h1008, 64'h101C};
    halt2     = 64'hFFFF_0000_0000_0040;

    b1.io_enable = 1'b0; b1.io_clear = 1'b0; b1.io_commit_valid = '0;
    b1.io_commit_pc = '0; b1.io_halt_pc_en = 1'b0; b1.io_halt_pc = '0;
    b2.io_enable = 1'b0; b2.io_clear = 1'b0; b2.io_commit_valid = '0;
    b2.io_commit_pc = '0; b2.io_halt_pc_en = 1'b0; b2.io_halt_pc = '0;
    b3.io_enable = 1'b0; b3.io_clear = 1'b0; b3.io_commit_valid = '0;
    b3.io_commit_pc = '0; b3.io_halt_pc_en = 1'b0; b3.io_halt_pc = '0;

    tick(2);
    check_b1_zero("reset");
    check("reset_b2_done", 64'(b2.io_done), 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Timeout: commit every cycle from the enabling cycle.
    b1.io_enable = 1'b1;
    b1.io_commit_valid = 1'b1;
    for (int k = 0; k < 999; k++) begin
      b1.io_commit_pc = 32'(k * 4);
      tick(1);
    end
    check("to_cyc999",    64'(b1.io_cycle_cnt), 64'd999);
    check("to_not_done",  64'(b1.io_done),      64'd0);
    b1.io_commit_pc = 32'(999 * 4);
    tick(1);
    check("to_done",   64'(b1.io_done),      64'd1);
    check("to_status", 64'(b1.io_status),    64'd2);
    check("to_cyc",    64'(b1.io_cycle_cnt), 64'd1000);
    check("to_instr",  64'(b1.io_instr_cnt), 64'd1000);
    check("to_lastpc", 64'(b1.io_last_pc),   64'd3996);
    b1.io_commit_pc = 32'h1234;
    tick(3);
    check("done_frozen_cyc",    64'(b1.io_cycle_cnt), 64'd1000);
    check("done_frozen_instr",  64'(b1.io_instr_cnt), 64'd1000);
    check("done_frozen_lastpc", 64'(b1.io_last_pc),   64'd3996);
    check("done_frozen_done",   64'(b1.io_done),      64'd1);
    clear_b1();
    check_b1_zero("clr1");

    // Stall: five commits, then silence.
    b1.io_enable = 1'b1;
    b1.io_commit_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b1.io_commit_pc = 32'(100 + k * 4);
      tick(1);
    end
    check("st_instr5", 64'(b1.io_instr_cnt), 64'd5);
    b1.io_commit_valid = 1'b0;
    tick(15);
    check("st_not_done15", 64'(b1.io_done), 64'd0);
    tick(1);
    check("st_done",   64'(b1.io_done),      64'd1);
    check("st_status", 64'(b1.io_status),    64'd3);
    check("st_instr",  64'(b1.io_instr_cnt), 64'd5);
    check("st_cyc",    64'(b1.io_cycle_cnt), 64'd21);
    check("st_lastpc", 64'(b1.io_last_pc),   64'd116);
    clear_b1();

    // Halt and timeout in the same cycle: halt wins.
    b1.io_halt_pc_en = 1'b1;
    b1.io_halt_pc    = 32'hDEAD_0000;
    b1.io_enable     = 1'b1;
    b1.io_commit_valid = 1'b1;
    for (int k = 0; k < 999; k++) begin
      b1.io_commit_pc = 32'(k * 4);
      tick(1);
    end
    check("ht_not_done", 64'(b1.io_done), 64'd0);
    b1.io_commit_pc = 32'hDEAD_0000;
    tick(1);
    check("ht_status", 64'(b1.io_status),    64'd1);
    check("ht_done",   64'(b1.io_done),      64'd1);
    check("ht_cyc",    64'(b1.io_cycle_cnt), 64'd1000);
    check("ht_instr",  64'(b1.io_instr_cnt), 64'd1000);
    check("ht_lastpc", 64'(b1.io_last_pc),   64'hDEAD_0000);
    b1.io_clear = 1'b1;
    tick(1);
    check_b1_zero("clr_prio");
    b1.io_clear = 1'b0;
    b1.io_enable = 1'b0;
    b1.io_halt_pc_en = 1'b0;
    tick(2);
    check_b1_zero("idle_after_clr");

    // Two lanes: pattern 11,01,00,10; invalid lanes carry the halt PC on 00 cycles.
    b2.io_halt_pc_en = 1'b1;
    b2.io_halt_pc    = halt2;
    b2.io_enable     = 1'b1;
    for (int r = 0; r < 25; r++) begin
      for (int p = 0; p < 4; p++) begin
        b2.io_commit_valid = pat[p];
        if (pat[p] == 2'b00) begin
          b2.io_commit_pc = {halt2, halt2};
        end else begin
          b2.io_commit_pc = {64'h1000 + 64'(r * 4 + p) * 8 + 64'd4,
                             64'h1000 + 64'(r * 4 + p) * 8};
        end
        tick(1);
        if (r == 0) begin
          check($sformatf("l2_lastpc_p%0d", p), b2.io_last_pc, exp_first[p]);
        end
      end
      if (r == 0) begin
        check("l2_instr_grp1", b2.io_instr_cnt, 64'd4);
      end
    end
    check("l2_instr100",  b2.io_instr_cnt, 64'd100);
    check("l2_not_done",  64'(b2.io_done), 64'd0);
    b2.io_commit_valid = 2'b11;
    b2.io_commit_pc    = {halt2, 64'h2000};
    tick(1);
    check("l2_status", 64'(b2.io_status), 64'd1);
    check("l2_done",   64'(b2.io_done),   64'd1);
    check("l2_instr",  b2.io_instr_cnt,   64'd102);
    check("l2_cyc",    b2.io_cycle_cnt,   64'd101);
    check("l2_lastpc", b2.io_last_pc,     halt2);
    b2.io_enable = 1'b0;
    b2.io_commit_valid = 2'b00;

    // 8-bit counters saturate; timeout and stall disabled.
    b3.io_enable = 1'b1;
    b3.io_commit_valid = 1'b1;
    b3.io_commit_pc = 16'h0ABC;
    tick(254);
    check("sat_cyc254", 64'(b3.io_cycle_cnt), 64'd254);
    tick(46);
    check("sat_cyc",    64'(b3.io_cycle_cnt), 64'd255);
    check("sat_instr",  64'(b3.io_instr_cnt), 64'd255);
    check("sat_done",   64'(b3.io_done),      64'd0);
    check("sat_status", 64'(b3.io_status),    64'd0);
    check("sat_lastpc", 64'(b3.io_last_pc),   64'h0ABC);

    // Pause and resume without clearing.
    b1.io_enable = 1'b1;
    b1.io_commit_valid = 1'b1;
    b1.io_commit_pc = 32'h40;
    tick(10);
    check("pause_cyc10", 64'(b1.io_cycle_cnt), 64'd10);
    b1.io_enable = 1'b0;
    tick(7);
    check("pause_hold_cyc",   64'(b1.io_cycle_cnt), 64'd10);
    check("pause_hold_instr", 64'(b1.io_instr_cnt), 64'd10);
    b1.io_enable = 1'b1;
    tick(10);
    check("resume_cyc",   64'(b1.io_cycle_cnt), 64'd20);
    check("resume_instr", 64'(b1.io_instr_cnt), 64'd20);
    check("resume_lastpc", 64'(b1.io_last_pc),  64'h40);

    // Asynchronous reset takes effect between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_b1_zero("areset");
    check("areset_b3_cyc", 64'(b3.io_cycle_cnt), 64'd0);
    check("areset_b2_done", 64'(b2.io_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
